// File: rtl/mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer_if
// Description : Control-unit handshake bundle for the shift-and-add multiply
//               sequencer: start/operands in, busy/done/product out.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_sequencer_if #(
   parameter int DATA_WIDTH = 8
);

   logic                      start;
   logic                      signed_mode;
   logic [DATA_WIDTH-1:0]     multiplicand;
   logic [DATA_WIDTH-1:0]     multiplier;
   logic                      busy;
   logic                      done;
   logic [2*DATA_WIDTH-1:0]   product;

   // Control unit side: issues requests, observes completion.
   modport master (
      output start,
      output signed_mode,
      output multiplicand,
      output multiplier,
      input  busy,
      input  done,
      input  product
   );

   // Sequencer side: accepts requests, reports completion.
   modport slave (
      input  start,
      input  signed_mode,
      input  multiplicand,
      input  multiplier,
      output busy,
      output done,
      output product
   );

endinterface
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Multi-cycle shift-and-add multiplier that borrows the CPU's
//               ALU. One ADD per multiplier bit, then two SUB correction
//               steps on the high half for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   mul_sequencer_if.slave             ctrl,
   output logic [DATA_WIDTH-1:0]      alu_op_a,
   output logic [DATA_WIDTH-1:0]      alu_op_b,
   output logic [2:0]                 alu_func,
   input  wire logic [DATA_WIDTH-1:0] alu_out,
   input  wire logic                  alu_carry
);

   localparam int              COUNT_W    = $clog2(DATA_WIDTH);
   localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DATA_WIDTH - 1);
   localparam logic [2:0]      FUNC_ADD   = 3'b000;
   localparam logic [2:0]      FUNC_SUB   = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP  = 3'd1,
      S_FIX_A = 3'd2,
      S_FIX_B = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                    state;
   state_t                    next_state;

   logic [DATA_WIDTH-1:0]     acc;
   logic [DATA_WIDTH-1:0]     lo;
   logic [DATA_WIDTH-1:0]     mcand;
   logic [DATA_WIDTH-1:0]     mplier_orig;
   logic [COUNT_W-1:0]        count;
   logic                      sgn;
   logic [2*DATA_WIDTH-1:0]   product;

   logic                      busy_c;
   logic                      done_c;

   // The ALU result shifted right by one, with the carry re-entering at the
   // top: this is the new high half after each add-and-shift step.
   logic [DATA_WIDTH-1:0]     step_acc;
   logic [DATA_WIDTH-1:0]     step_lo;

   assign step_acc = {alu_carry, alu_out[DATA_WIDTH-1:1]};
   assign step_lo  = {alu_out[0], lo[DATA_WIDTH-1:1]};

   assign ctrl.busy    = busy_c;
   assign ctrl.done    = done_c;
   assign ctrl.product = product;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus combinational ALU drive and handshake outputs.
   always_comb begin
      next_state = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      alu_op_a   = '0;
      alu_op_b   = '0;
      alu_func   = FUNC_ADD;

      case (state)
         S_IDLE: begin
            if (ctrl.start) begin
               next_state = S_STEP;
            end
         end

         S_STEP: begin
            busy_c   = 1'b1;
            alu_func = FUNC_ADD;
            alu_op_a = acc;
            // Adding zero when the current multiplier bit is clear keeps the
            // carry at zero, so the shift is correct either way.
            alu_op_b = lo[0] ? mcand : '0;
            if (count == '0) begin
               next_state = sgn ? S_FIX_A : S_DONE;
            end
         end

         S_FIX_A: begin
            // Negative multiplier: its top bit carried weight -2^(W-1), so
            // the unsigned result over-counted mcand * 2^W.
            busy_c     = 1'b1;
            alu_func   = FUNC_SUB;
            alu_op_a   = acc;
            alu_op_b   = mplier_orig[DATA_WIDTH-1] ? mcand : '0;
            next_state = S_FIX_B;
         end

         S_FIX_B: begin
            // Same correction for a negative multiplicand, using the
            // original multiplier bits.
            busy_c     = 1'b1;
            alu_func   = FUNC_SUB;
            alu_op_a   = acc;
            alu_op_b   = mcand[DATA_WIDTH-1] ? mplier_orig : '0;
            next_state = S_DONE;
         end

         S_DONE: begin
            done_c     = 1'b1;
            next_state = S_IDLE;
         end

         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Operand capture, partial-product datapath and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         lo          <= '0;
         mcand       <= '0;
         mplier_orig <= '0;
         count       <= '0;
         sgn         <= 1'b0;
         product     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl.start) begin
                  acc         <= '0;
                  lo          <= ctrl.multiplier;
                  mcand       <= ctrl.multiplicand;
                  mplier_orig <= ctrl.multiplier;
                  sgn         <= ctrl.signed_mode;
                  count       <= COUNT_LAST;
               end
            end

            S_STEP: begin
               acc <= step_acc;
               lo  <= step_lo;
               if (count != '0) begin
                  count <= count - COUNT_W'(1);
               end else if (!sgn) begin
                  // Unsigned result is complete after the last step.
                  product <= {step_acc, step_lo};
               end
            end

            S_FIX_A: begin
               // Borrow out of the correction is meaningless modulo 2^W.
               acc <= alu_out;
            end

            S_FIX_B: begin
               acc     <= alu_out;
               product <= {alu_out, lo};
            end

            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Self-checking bench for mul_sequencer with a behavioural ALU
//               and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

   localparam int         W        = 8;
   localparam logic [2:0] FUNC_ADD = 3'b000;
   localparam logic [2:0] FUNC_SUB = 3'b001;
   localparam int         WINDOW   = 30;

   logic           clk;
   logic           rst_n;
   logic [W-1:0]   alu_op_a;
   logic [W-1:0]   alu_op_b;
   logic [2:0]     alu_func;
   logic [W-1:0]   alu_out;
   logic           alu_carry;

   int checks;
   int errors;

   mul_sequencer_if #(.DATA_WIDTH(W)) ctrl_if ();

   mul_sequencer #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctrl      (ctrl_if.slave),
      .alu_op_a  (alu_op_a),
      .alu_op_b  (alu_op_b),
      .alu_func  (alu_func),
      .alu_out   (alu_out),
      .alu_carry (alu_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: ADD reports carry-out, SUB reports borrow.
   always_comb begin
      if (alu_func == FUNC_SUB) begin
         {alu_carry, alu_out} = {1'b0, alu_op_a} - {1'b0, alu_op_b};
      end else begin
         {alu_carry, alu_out} = {1'b0, alu_op_a} + {1'b0, alu_op_b};
      end
   end

   // Reference product: plain integer multiplication, truncated to 2W bits.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sm);
      longint pa;
      longint pb;
      longint p;
      pa = sm ? longint'($signed(a)) : longint'(a);
      pb = sm ? longint'($signed(b)) : longint'(b);
      p  = pa * pb;
      return p[2*W-1:0];
   endfunction

   // Launch one operation and observe it for a fixed window. Optionally
   // pulses start with other operands partway through the operation.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input int inject_at,
                         output logic [2*W-1:0] prod, output int lat, output int busy_n,
                         output int sub_n, output int done_n,
                         output logic [W-1:0] fixa_opb, output logic [W-1:0] fixb_opb);
      @(negedge clk);
      ctrl_if.start        = 1'b1;
      ctrl_if.signed_mode  = sm;
      ctrl_if.multiplicand = a;
      ctrl_if.multiplier   = b;
      @(posedge clk);
      #1;
      ctrl_if.start = 1'b0;
      lat = -1; busy_n = 0; sub_n = 0; done_n = 0;
      fixa_opb = 'x; fixb_opb = 'x;
      for (int k = 0; k < WINDOW; k++) begin
         @(negedge clk);
         if (k == inject_at) begin
            ctrl_if.start        = 1'b1;
            ctrl_if.signed_mode  = ~sm;
            ctrl_if.multiplicand = 8'h02;
            ctrl_if.multiplier   = 8'h03;
         end else begin
            ctrl_if.start = 1'b0;
         end
         if (ctrl_if.busy) busy_n++;
         if (alu_func == FUNC_SUB) begin
            if (sub_n == 0) fixa_opb = alu_op_b;
            else            fixb_opb = alu_op_b;
            sub_n++;
         end
         if (ctrl_if.done) begin
            done_n++;
            if (lat < 0) lat = k;
         end
      end
      ctrl_if.start = 1'b0;
      prod = ctrl_if.product;
   endtask

   task automatic test_reset();
      rst_n                = 1'b0;
      ctrl_if.start        = 1'b0;
      ctrl_if.signed_mode  = 1'b0;
      ctrl_if.multiplicand = '0;
      ctrl_if.multiplier   = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (ctrl_if.busy !== 1'b0 || ctrl_if.done !== 1'b0 || ctrl_if.product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b product=%h, expected 0 0 0000",
                  ctrl_if.busy, ctrl_if.done, ctrl_if.product);
      end
      checks++;
      if (alu_op_a !== 8'h00 || alu_op_b !== 8'h00 || alu_func !== FUNC_ADD) begin
         errors++;
         $display("FAIL reset_alu: op_a=%h op_b=%h func=%b, expected 00 00 000",
                  alu_op_a, alu_op_b, alu_func);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned_basic();
      logic [2*W-1:0] p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      run_op(8'h0D, 8'h0B, 1'b0, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'h008F) begin
         errors++; $display("FAIL u13x11_product: got %h expected 008f", p);
      end
      checks++;
      if (lat !== W || dn !== 1) begin
         errors++; $display("FAIL u13x11_done: latency=%0d pulses=%0d expected %0d 1", lat, dn, W);
      end
      checks++;
      if (bn !== W || sn !== 0) begin
         errors++; $display("FAIL u13x11_busy: busy=%0d sub=%0d expected %0d 0", bn, sn, W);
      end
   endtask

   task automatic test_ff();
      logic [2*W-1:0] p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      run_op(8'hFF, 8'hFF, 1'b0, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'hFE01 || lat !== W) begin
         errors++; $display("FAIL uFFxFF: product=%h latency=%0d expected fe01 %0d", p, lat, W);
      end
      run_op(8'hFF, 8'hFF, 1'b1, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'h0001) begin
         errors++; $display("FAIL sFFxFF_product: got %h expected 0001", p);
      end
      checks++;
      if (lat !== W + 2 || dn !== 1 || bn !== W + 2) begin
         errors++; $display("FAIL sFFxFF_timing: latency=%0d pulses=%0d busy=%0d expected %0d 1 %0d",
                            lat, dn, bn, W + 2, W + 2);
      end
      checks++;
      if (sn !== 2 || fa !== 8'hFF || fb !== 8'hFF) begin
         errors++; $display("FAIL sFFxFF_fix: sub=%0d fixa_opb=%h fixb_opb=%h expected 2 ff ff",
                            sn, fa, fb);
      end
   endtask

   task automatic test_signed_80_7f();
      logic [2*W-1:0] p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      run_op(8'h80, 8'h7F, 1'b1, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'hC080) begin
         errors++; $display("FAIL s80x7F_product: got %h expected c080", p);
      end
      checks++;
      if (fb !== 8'h7F || fa !== 8'h00 || sn !== 2) begin
         errors++; $display("FAIL s80x7F_fix: fixa_opb=%h fixb_opb=%h sub=%0d expected 00 7f 2",
                            fa, fb, sn);
      end
      run_op(8'h7F, 8'h80, 1'b1, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'hC080 || fa !== 8'h7F || fb !== 8'h00) begin
         errors++; $display("FAIL s7Fx80: product=%h fixa_opb=%h fixb_opb=%h expected c080 7f 00",
                            p, fa, fb);
      end
   endtask

   task automatic test_zero_and_ignore();
      logic [2*W-1:0] p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      for (int m = 0; m < 2; m++) begin
         run_op(8'h00, 8'hAB, 1'(m), 3, p, lat, bn, sn, dn, fa, fb);
         checks++;
         if (p !== 16'h0000 || dn !== 1) begin
            errors++; $display("FAIL zero_mode%0d: product=%h pulses=%0d expected 0000 1", m, p, dn);
         end
         checks++;
         if (lat !== (m != 0 ? W + 2 : W) || bn !== lat) begin
            errors++; $display("FAIL zero_mode%0d_timing: latency=%0d busy=%0d", m, lat, bn);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2*W-1:0] p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      int pulses;
      @(negedge clk);
      ctrl_if.start        = 1'b1;
      ctrl_if.signed_mode  = 1'b0;
      ctrl_if.multiplicand = 8'hFF;
      ctrl_if.multiplier   = 8'hFF;
      @(posedge clk);
      #1;
      ctrl_if.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctrl_if.busy !== 1'b0 || ctrl_if.product !== 16'h0000 || ctrl_if.done !== 1'b0) begin
         errors++; $display("FAIL midreset_async: busy=%b product=%h done=%b expected 0 0000 0",
                            ctrl_if.busy, ctrl_if.product, ctrl_if.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (ctrl_if.done) pulses++;
      end
      checks++;
      if (pulses !== 0 || ctrl_if.product !== 16'h0000) begin
         errors++; $display("FAIL midreset_quiet: pulses=%0d product=%h expected 0 0000",
                            pulses, ctrl_if.product);
      end
      run_op(8'h03, 8'h05, 1'b0, -1, p, lat, bn, sn, dn, fa, fb);
      checks++;
      if (p !== 16'h000F || dn !== 1) begin
         errors++; $display("FAIL midreset_after: product=%h pulses=%0d expected 000f 1", p, dn);
      end
   endtask

   task automatic test_back_to_back();
      int at[$];
      int bad_prod;
      @(negedge clk);
      ctrl_if.start        = 1'b1;
      ctrl_if.signed_mode  = 1'b0;
      ctrl_if.multiplicand = 8'h02;
      ctrl_if.multiplier   = 8'h02;
      bad_prod = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ctrl_if.done) begin
            at.push_back(k);
            if (ctrl_if.product !== 16'h0004) bad_prod++;
            if (at.size() == 3) ctrl_if.start = 1'b0;
         end
      end
      ctrl_if.start = 1'b0;
      checks++;
      if (at.size() !== 3 || bad_prod !== 0) begin
         errors++; $display("FAIL b2b_count: pulses=%0d bad_products=%0d expected 3 0",
                            at.size(), bad_prod);
      end
      checks++;
      if (at.size() != 3 || at[1] - at[0] !== 10 || at[2] - at[1] !== 10) begin
         errors++; $display("FAIL b2b_period: pulse cycles=%p expected spacing 10", at);
      end
   endtask

   task automatic test_random();
      logic [2*W-1:0] p, exp_p; int lat, bn, sn, dn; logic [W-1:0] fa, fb;
      logic [W-1:0] a, b; logic sm;
      for (int n = 0; n < 24; n++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         sm = 1'($urandom);
         exp_p = ref_mul(a, b, sm);
         run_op(a, b, sm, -1, p, lat, bn, sn, dn, fa, fb);
         checks++;
         if (p !== exp_p || lat !== (sm ? W + 2 : W) || dn !== 1) begin
            errors++; $display("FAIL random_%0d: %h x %h sm=%b product=%h latency=%0d expected %h %0d",
                               n, a, b, sm, p, lat, exp_p, sm ? W + 2 : W);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unsigned_basic();
      test_ff();
      test_signed_80_7f();
      test_reset_mid();
      test_zero_and_ignore();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
